// File: rtl/qsfp_mgmt_ctrl_if.sv
// ============================================================================
//  Module      : qsfp_mgmt_ctrl_if
//  Description : QSFP28 sideband pins plus host control/status bundle for one
//                cage. The master side is the sequencer; the slave side is the
//                module cage together with the register block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qsfp_mgmt_ctrl_if;
    // Cage pins
    logic       qsfp_modprsl;
    logic       qsfp_intl;
    logic       qsfp_resetl;
    logic       qsfp_lpmode;
    logic       qsfp_modsell;
    // Host control
    logic       ctrl_enable;
    logic       ctrl_lpmode;
    logic       ctrl_reset_req;
    logic       irq_clear;
    // Host status
    logic [2:0] status_state;
    logic       status_present;
    logic       status_ready;
    logic       irq_pending;
    logic [7:0] insert_count;

    modport master (
        input  qsfp_modprsl, qsfp_intl,
        input  ctrl_enable, ctrl_lpmode, ctrl_reset_req, irq_clear,
        output qsfp_resetl, qsfp_lpmode, qsfp_modsell,
        output status_state, status_present, status_ready, irq_pending, insert_count
    );

    modport slave (
        output qsfp_modprsl, qsfp_intl,
        output ctrl_enable, ctrl_lpmode, ctrl_reset_req, irq_clear,
        input  qsfp_resetl, qsfp_lpmode, qsfp_modsell,
        input  status_state, status_present, status_ready, irq_pending, insert_count
    );
endinterface

`default_nettype wire

// File: rtl/qsfp_mgmt_ctrl.sv
// ============================================================================
//  Module      : qsfp_mgmt_ctrl
//  Description : Per-cage QSFP28 sideband sequencer. Debounces ModPrsL, applies
//                a timed ResetL pulse and init wait after insertion, then drives
//                LPMode/ModSelL from host control and latches events for the
//                register block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qsfp_mgmt_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned RESET_CYCLES    = 2500,
    parameter int unsigned INIT_CYCLES     = 500000000,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    qsfp_mgmt_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_ABSENT   = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_RESET    = 3'd3,
        ST_INIT     = 3'd4,
        ST_READY    = 3'd5
    } state_t;

    // Terminal timer values: a timed state is left on the cycle the timer
    // reaches its last count, so it lasts exactly *_CYCLES cycles.
    localparam logic [CNT_WIDTH-1:0] DEBOUNCE_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RESET_LAST    = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] INIT_LAST     = CNT_WIDTH'(INIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMER_ONE     = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   timer;
    logic                   removed;
    logic                   irq_set;

    logic                   prs_meta;
    logic                   prs_sync;
    logic                   intl_meta;
    logic                   intl_sync;
    logic                   present;

    logic                   resetl;
    logic                   lpmode;
    logic                   modsell;
    logic                   ready;
    logic                   irq;
    logic [7:0]             inserts;

    // Two-flop synchronizers for the asynchronous cage pins; reset to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_meta  <= 1'b1;
            prs_sync  <= 1'b1;
            intl_meta <= 1'b1;
            intl_sync <= 1'b1;
        end else begin
            prs_meta  <= bus.qsfp_modprsl;
            prs_sync  <= prs_meta;
            intl_meta <= bus.qsfp_intl;
            intl_sync <= intl_meta;
        end
    end

    assign present = ~prs_sync;

    // Next-state decision; enable, removal and reset request are checked in
    // that order before the normal timed progression.
    always_comb begin
        state_next = state;
        removed    = 1'b0;
        if (!bus.ctrl_enable) begin
            state_next = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED: state_next = ST_ABSENT;
                ST_ABSENT: begin
                    if (present) state_next = ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (!present)                    state_next = ST_ABSENT;
                    else if (timer == DEBOUNCE_LAST) state_next = ST_RESET;
                end
                ST_RESET: begin
                    if (!present) begin
                        state_next = ST_ABSENT;
                        removed    = 1'b1;
                    end else if (timer == RESET_LAST) begin
                        state_next = ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (!present) begin
                        state_next = ST_ABSENT;
                        removed    = 1'b1;
                    end else if (bus.ctrl_reset_req) begin
                        state_next = ST_RESET;
                    end else if (timer == INIT_LAST) begin
                        state_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (!present) begin
                        state_next = ST_ABSENT;
                        removed    = 1'b1;
                    end else if (bus.ctrl_reset_req) begin
                        state_next = ST_RESET;
                    end
                end
                default: state_next = ST_DISABLED;
            endcase
        end
    end

    // Event sources for the sticky interrupt flag: READY entry, removal from
    // an active state, and the module interrupt level while READY.
    assign irq_set = ((state_next == ST_READY) && (state != ST_READY)) ||
                     removed ||
                     ((state == ST_READY) && !intl_sync);

    // State register, shared timer and outputs registered from next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_DISABLED;
            timer   <= '0;
            resetl  <= 1'b0;
            lpmode  <= 1'b1;
            modsell <= 1'b1;
            ready   <= 1'b0;
            irq     <= 1'b0;
            inserts <= 8'd0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if ((state == ST_DEBOUNCE) || (state == ST_RESET) || (state == ST_INIT)) begin
                timer <= timer + TIMER_ONE;
            end
            resetl  <= (state_next == ST_INIT) || (state_next == ST_READY);
            lpmode  <= (state_next == ST_READY) ? bus.ctrl_lpmode : 1'b1;
            modsell <= (state_next != ST_READY);
            ready   <= (state_next == ST_READY);
            irq     <= irq_set | (irq & ~bus.irq_clear);
            if ((state == ST_INIT) && (state_next == ST_READY) && (inserts != 8'hFF)) begin
                inserts <= inserts + 8'd1;
            end
        end
    end

    assign bus.qsfp_resetl    = resetl;
    assign bus.qsfp_lpmode    = lpmode;
    assign bus.qsfp_modsell   = modsell;
    assign bus.status_state   = state;
    assign bus.status_present = present;
    assign bus.status_ready   = ready;
    assign bus.irq_pending    = irq;
    assign bus.insert_count   = inserts;

endmodule

`default_nettype wire
